// File: rtl/gate_sweep_checker_if.sv
// Handshake and result bus between the gate sweep checker and its environment.
// The checker drives the gate operands and reports results. The environment
// requests sweeps and returns the gate block's result word.
interface gate_sweep_checker_if;
    logic       start;
    logic [6:0] y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic [2:0] err_count;
    logic [3:0] err_mask;
    logic [6:0] fail_bits;

    modport master (
        input  start,
        input  y,
        output a,
        output b,
        output busy,
        output done,
        output err_count,
        output err_mask,
        output fail_bits
    );

    modport slave (
        output start,
        output y,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  err_count,
        input  err_mask,
        input  fail_bits
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Gate sweep checker. On each accepted start, the checker steps the operands {a,b}
// through 00, 01, 10 and 11. It holds each pair for SETTLE cycles and then samples
// the result word of the downstream gate block. Each sampled word is compared
// against the ideal seven-gate response. Per-combination error flags, the number
// of failing combinations, and the OR of all differing bits accumulate across the
// sweep. They stay readable until the next accepted start.
module gate_sweep_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_sweep_checker_if.master bus
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       idx, idx_nx;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic             a_r, a_nx;
    logic             b_r, b_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;
    logic [2:0]       err_count_r, err_count_nx;
    logic [3:0]       err_mask_r, err_mask_nx;
    logic [6:0]       fail_bits_r, fail_bits_nx;
    logic [6:0]       diff;

    // Ideal gate-block response: {xnor, xor, nor, nand, or, and, not-a}.
    function automatic logic [6:0] gate_expect(input logic ia, input logic ib);
        return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ia | ib, ia & ib, ~ia};
    endfunction

    // Error count never exceeds the four combinations; hold at 4 regardless.
    function automatic logic [2:0] count_inc(input logic [2:0] c);
        return (c >= 3'd4) ? 3'd4 : c + 3'd1;
    endfunction

    // Difference between the observed word and the ideal word for the operands on the bus.
    always_comb diff = bus.y ^ gate_expect(a_r, b_r);

    // Next-state and next-output decode; every register holds unless a state acts on it.
    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        wait_cnt_nx  = wait_cnt;
        a_nx         = a_r;
        b_nx         = b_r;
        busy_nx      = busy_r;
        done_nx      = 1'b0;
        err_count_nx = err_count_r;
        err_mask_nx  = err_mask_r;
        fail_bits_nx = fail_bits_r;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_nx       = 2'd0;
                    a_nx         = 1'b0;
                    b_nx         = 1'b0;
                    wait_cnt_nx  = '0;
                    err_count_nx = 3'd0;
                    err_mask_nx  = 4'd0;
                    fail_bits_nx = 7'd0;
                    busy_nx      = 1'b1;
                    state_nx     = WAIT;
                end
            end

            WAIT: begin
                wait_cnt_nx = wait_cnt + 1'b1;
                if (wait_cnt == CNT_W'(SETTLE - 1)) begin
                    state_nx = SAMPLE;
                end
            end

            SAMPLE: begin
                if (diff != 7'd0) begin
                    err_mask_nx[idx] = 1'b1;
                    err_count_nx     = count_inc(err_count_r);
                    fail_bits_nx     = fail_bits_r | diff;
                end
                if (idx != 2'd3) begin
                    idx_nx         = idx + 2'd1;
                    {a_nx, b_nx}   = idx + 2'd1;
                    wait_cnt_nx    = '0;
                    state_nx       = WAIT;
                end else begin
                    done_nx  = 1'b1;
                    state_nx = FINISH;
                end
            end

            FINISH: begin
                busy_nx  = 1'b0;
                a_nx     = 1'b0;
                b_nx     = 1'b0;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 2'd0;
            wait_cnt    <= '0;
            a_r         <= 1'b0;
            b_r         <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_count_r <= 3'd0;
            err_mask_r  <= 4'd0;
            fail_bits_r <= 7'd0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            wait_cnt    <= wait_cnt_nx;
            a_r         <= a_nx;
            b_r         <= b_nx;
            busy_r      <= busy_nx;
            done_r      <= done_nx;
            err_count_r <= err_count_nx;
            err_mask_r  <= err_mask_nx;
            fail_bits_r <= fail_bits_nx;
        end
    end

    assign bus.a         = a_r;
    assign bus.b         = b_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err_count = err_count_r;
    assign bus.err_mask  = err_mask_r;
    assign bus.fail_bits = fail_bits_r;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker. It runs two instances, one with SETTLE=2 and one with SETTLE=1.
// A behavioural gate block supports selectable faults. Expected results are queued when a sweep starts.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gate_sweep_checker_if if0 ();
    gate_sweep_checker_if if1 ();

    gate_sweep_checker #(.SETTLE(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    gate_sweep_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));

    typedef struct packed {
        logic [2:0] count;
        logic [3:0] mask;
        logic [6:0] fail;
    } result_t;

    result_t sb_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      fault_mode = 0;   // 0 correct, 1 y tied low, 2 y[5] stuck at 0
    logic    sel = 1'b0;       // 0 -> SETTLE=2 instance, 1 -> SETTLE=1 instance

    function automatic logic [6:0] gate_ref(input logic ia, input logic ib);
        return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ia | ib, ia & ib, ~ia};
    endfunction

    function automatic logic [6:0] apply_fault(input logic [6:0] v, input int mode);
        case (mode)
            1:       return 7'd0;
            2:       return v & 7'b1011111;
            default: return v;
        endcase
    endfunction

    always_comb if0.y = apply_fault(gate_ref(if0.a, if0.b), fault_mode);
    always_comb if1.y = apply_fault(gate_ref(if1.a, if1.b), fault_mode);

    logic [1:0] cur_ab;
    logic       cur_busy, cur_done;
    logic [2:0] cur_cnt;
    logic [3:0] cur_mask;
    logic [6:0] cur_fail;

    assign cur_ab   = sel ? {if1.a, if1.b} : {if0.a, if0.b};
    assign cur_busy = sel ? if1.busy : if0.busy;
    assign cur_done = sel ? if1.done : if0.done;
    assign cur_cnt  = sel ? if1.err_count : if0.err_count;
    assign cur_mask = sel ? if1.err_mask : if0.err_mask;
    assign cur_fail = sel ? if1.fail_bits : if0.fail_bits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) if1.start = v;
        else     if0.start = v;
    endtask

    function automatic result_t predict(input int mode);
        result_t r;
        logic [6:0] e, d;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            e = gate_ref(i[1], i[0]);
            d = apply_fault(e, mode) ^ e;
            if (d != 7'd0) begin
                r.count   = r.count + 3'd1;
                r.mask[i] = 1'b1;
                r.fail    = r.fail | d;
            end
        end
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ab0"},   {30'd0, {if0.a, if0.b}}, 0);
        chk({tag, "_busy0"}, {31'd0, if0.busy}, 0);
        chk({tag, "_done0"}, {31'd0, if0.done}, 0);
        chk({tag, "_cnt0"},  {29'd0, if0.err_count}, 0);
        chk({tag, "_mask0"}, {28'd0, if0.err_mask}, 0);
        chk({tag, "_fail0"}, {25'd0, if0.fail_bits}, 0);
        chk({tag, "_busy1"}, {31'd0, if1.busy}, 0);
        chk({tag, "_ab1"},   {30'd0, {if1.a, if1.b}}, 0);
    endtask

    // One complete sweep on the selected instance, checked cycle by cycle.
    task automatic sweep(input int settle, input int mode, input bit repulse);
        int hold, total;
        result_t exp_r;
        hold  = settle + 1;
        total = 4 * hold;
        fault_mode = mode;
        sb_q.push_back(predict(mode));
        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        chk("cap_busy", {31'd0, cur_busy}, 1);
        chk("cap_ab",   {30'd0, cur_ab}, 0);
        chk("cap_cnt",  {29'd0, cur_cnt}, 0);
        chk("cap_mask", {28'd0, cur_mask}, 0);
        chk("cap_fail", {25'd0, cur_fail}, 0);
        exp_r = '0;
        for (int n = 1; n <= total + 1; n++) begin
            @(posedge clk); #1;
            if (n < total) begin
                chk("ab_step", {30'd0, cur_ab}, n / hold);
                chk("done_lo", {31'd0, cur_done}, 0);
                chk("busy_hi", {31'd0, cur_busy}, 1);
            end else if (n == total) begin
                chk("done_hi", {31'd0, cur_done}, 1);
                chk("ab_end",  {30'd0, cur_ab}, 3);
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    exp_r = sb_q.pop_front();
                    chk("err_count", {29'd0, cur_cnt},  {29'd0, exp_r.count});
                    chk("err_mask",  {28'd0, cur_mask}, {28'd0, exp_r.mask});
                    chk("fail_bits", {25'd0, cur_fail}, {25'd0, exp_r.fail});
                end
            end else begin
                chk("done_off", {31'd0, cur_done}, 0);
                chk("busy_off", {31'd0, cur_busy}, 0);
                chk("ab_idle",  {30'd0, cur_ab}, 0);
            end
            if (repulse && n == hold + 1) set_start(1'b1);
            if (repulse && n == hold + 2) set_start(1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("hold_cnt",  {29'd0, cur_cnt},  {29'd0, exp_r.count});
        chk("hold_mask", {28'd0, cur_mask}, {28'd0, exp_r.mask});
        chk("hold_fail", {25'd0, cur_fail}, {25'd0, exp_r.fail});
        chk("hold_busy", {31'd0, cur_busy}, 0);
    endtask

    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        #1;
        check_all_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Correct gate block, then the two faulty blocks, then a re-pulsed start.
        sweep(2, 0, 1'b0);
        sweep(2, 1, 1'b0);
        chk("exp00", {25'd0, gate_ref(1'b0, 1'b0)}, 32'h59);
        sweep(2, 2, 1'b0);
        sweep(2, 0, 1'b1);

        // Reset asserted mid-sweep while {a,b}=10.
        fault_mode = 1;
        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_ab",  {30'd0, cur_ab}, 2);
        chk("pre_rst_cnt", {29'd0, cur_cnt}, 2);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #3 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("post_rst_busy", {31'd0, cur_busy}, 0);
            chk("post_rst_ab",   {30'd0, cur_ab}, 0);
            chk("post_rst_done", {31'd0, cur_done}, 0);
        end
        sweep(2, 0, 1'b0);

        // Shortest settle time.
        sel = 1'b1;
        sweep(1, 0, 1'b0);
        sweep(1, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop if the run overruns.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 2, the number of cycles a and b are held before y is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a sweep; sampled only in IDLE.
REQ-005 SHALL have port y  input  7  result bus from the downstream gate block: {xnor, xor, nor, nand, or, and, not-a}, bit0 = not-a.
REQ-006 SHALL have port a  output  1  gate operand a driven to the gate block.
REQ-007 SHALL have port b  output  1  gate operand b driven to the gate block.
REQ-008 SHALL have port busy  output  1  high from sweep start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-010 SHALL have port err_count  output  3  number of combinations with any mismatch, range 0..4.
REQ-011 SHALL have port err_mask  output  4  bit i set when combination i, i = {a,b}, mismatched.
REQ-012 SHALL have port fail_bits  output  7  OR across all combinations of (y XOR expected).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, SAMPLE, FINISH, all outputs registered.
REQ-014 IDLE with start=1 SHALL set the following at the next edge: idx=0, a=0, b=0, wait counter=0, err_count/err_mask/fail_bits=0, busy=1, and move to WAIT.
REQ-015 IDLE with start=0 SHALL hold all outputs, including the previous results.
REQ-016 WAIT SHALL increment the wait counter each edge and move to SAMPLE on the edge where counter == SETTLE-1; a and b SHALL stay constant.
REQ-017 SAMPLE SHALL compare y against the expected value for the current {a,b}: expected = {~(a^b), a^b, ~(a|b), ~(a&b), a|b, a&b, ~a}.
REQ-018 On a mismatch in SAMPLE, the next edge SHALL set err_mask[idx], increment err_count by 1, and OR the XOR difference into fail_bits.
REQ-019 SAMPLE with idx<3 SHALL, at that edge, increment idx, drive {a,b}=idx+1, clear the wait counter, and return to WAIT.
REQ-020 SAMPLE with idx==3 SHALL move to FINISH with done=1; a and b hold 1,1.
REQ-021 FINISH SHALL last one cycle, then return to IDLE with done=0, busy=0, and a=b=0.
REQ-022 The sweep order SHALL be {a,b} = 00, 01, 10, 11; each pair held SETTLE+1 cycles.
REQ-023 done SHALL be high for exactly one cycle, beginning 4*(SETTLE+1) rising edges after the edge that captured start.
REQ-024 start SHALL be ignored in WAIT, SAMPLE and FINISH; it is never queued.
REQ-025 err_count SHALL saturate at 4 by construction; no wrap is possible.
REQ-026 Results SHALL update live during a sweep, be final when done is asserted, and hold until the next accepted start.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for clk, force state=IDLE and a, b, busy, done, err_count, err_mask, fail_bits, idx and the wait counter all to 0.
REQ-028 After rst_n deasserts, the block SHALL stay idle until start is sampled high; a sweep interrupted by reset SHALL NOT resume.

Verification
REQ-029 Correct gate block, SETTLE=2, one start pulse -> a,b step 00,01,10,11, each held 3 cycles; done at edge 12; err_count=0, err_mask=4'b0000, fail_bits=7'b0000000.
REQ-030 y tied to 7'b0000000 -> err_count=4, err_mask=4'b1111, fail_bits=7'b1111111; expected value for 00 is 7'b1011001.
REQ-031 y[5] stuck at 0, other bits correct -> err_mask=4'b0110, err_count=2, fail_bits=7'b0100000.
REQ-032 start re-pulsed during WAIT of combination 01 -> ignored, exactly one done pulse, sweep timing unchanged; start in a later IDLE begins a new sweep and clears the results.
REQ-033 rst_n pulsed low while {a,b}=10 -> a=b=0, busy=0, done=0, results=0 with no clock edge needed; no activity after release until start.
REQ-034 SETTLE=1 -> each pair held 2 cycles; done at edge 8 after start capture; results as in REQ-029.
